// File: rtl/riscv_tpr_ctrl_pkg.sv
// Shared definitions for the Tag Propagation Register controller: CSR address,
// CSR operation encoding, FSM states and the CSR read-modify-write helper.
package riscv_tpr_ctrl_pkg;

    localparam logic [11:0] CSR_TPR = 12'h7C0;
    localparam int          TPR_W   = 32;

    // Bit fields of csr_op_i
    localparam int CSR_OP_HIGH = 1;
    localparam int CSR_OP_LOW  = 0;

    typedef enum logic [CSR_OP_HIGH:CSR_OP_LOW] {
        CSR_OP_NONE  = 2'b00,
        CSR_OP_WRITE = 2'b01,
        CSR_OP_SET   = 2'b10,
        CSR_OP_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        TPR_IDLE   = 2'b00,
        TPR_DRAIN  = 2'b01,
        TPR_COMMIT = 2'b10
    } tpr_state_e;

    function automatic logic [TPR_W-1:0] tpr_csr_apply(
        input csr_op_e          op,
        input logic [TPR_W-1:0] base,
        input logic [TPR_W-1:0] wdata
    );
        logic [TPR_W-1:0] res;
        case (op)
            CSR_OP_WRITE: res = wdata;
            CSR_OP_SET:   res = base | wdata;
            CSR_OP_CLEAR: res = base & ~wdata;
            default:      res = base;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/riscv_tpr_ctrl_if.sv
// CSR access bus between the CSR path (master) and the TPR controller (slave).
interface riscv_tpr_ctrl_if;

    logic                          csr_access_i;
    logic [11:0]                   csr_addr_i;
    riscv_tpr_ctrl_pkg::csr_op_e   csr_op_i;
    logic [31:0]                   csr_wdata_i;
    logic [31:0]                   csr_rdata_o;

    modport master (
        output csr_access_i,
        output csr_addr_i,
        output csr_op_i,
        output csr_wdata_i,
        input  csr_rdata_o
    );

    modport slave (
        input  csr_access_i,
        input  csr_addr_i,
        input  csr_op_i,
        input  csr_wdata_i,
        output csr_rdata_o
    );

endinterface

// File: rtl/riscv_tpr_ctrl.sv
// Owner of the Tag Propagation Register: CSR writes are staged in pend_q and
// committed to tpr_o only after the pipeline has drained; a lock bit freezes it.
module riscv_tpr_ctrl
    import riscv_tpr_ctrl_pkg::*;
#(
    parameter logic [31:0] TPR_RESET    = 32'h0000_0000,
    parameter logic [31:0] TPR_WMASK    = 32'hFFFF_FFFF,
    parameter int          LOCK_BIT     = 31,
    parameter int          DRAIN_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    riscv_tpr_ctrl_if.slave        csr,
    input  logic                   pipe_empty_i,
    output logic [31:0]            tpr_o,
    output logic                   tpr_stall_o,
    output logic                   tpr_update_o,
    output logic                   tpr_lock_err_o
);

    localparam int              CNT_W    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    tpr_state_e       state_q;
    logic [31:0]      tpr_q;
    logic [31:0]      pend_q;
    logic [CNT_W-1:0] cnt_q;
    logic             stall_q;
    logic             update_q;
    logic             lock_err_q;

    logic             wr_hit;
    logic             wr_readonly;
    logic             wr_eff;
    logic             locked;
    logic             wr_ok;
    logic [31:0]      base;
    logic [31:0]      new_val;

    function automatic logic [31:0] apply_wmask(input logic [31:0] val);
        return (val & TPR_WMASK) | (TPR_RESET & ~TPR_WMASK);
    endfunction

    assign wr_hit = csr.csr_access_i && (csr.csr_addr_i == CSR_TPR) &&
                    (csr.csr_op_i != CSR_OP_NONE);

    // SET/CLEAR with a zero operand is a pure read and must not start a drain.
    assign wr_readonly = ((csr.csr_op_i == CSR_OP_SET) || (csr.csr_op_i == CSR_OP_CLEAR)) &&
                         (csr.csr_wdata_i == 32'h0);

    assign wr_eff  = wr_hit && !wr_readonly;
    assign locked  = tpr_q[LOCK_BIT];
    assign wr_ok   = wr_eff && !locked;

    // In COMMIT pend_q already equals tpr_q, so either source is correct there.
    assign base    = (state_q != TPR_IDLE) ? pend_q : tpr_q;
    assign new_val = apply_wmask(tpr_csr_apply(csr.csr_op_i, base, csr.csr_wdata_i));

    assign csr.csr_rdata_o = base;
    assign tpr_o           = tpr_q;
    assign tpr_stall_o     = stall_q;
    assign tpr_update_o    = update_q;
    assign tpr_lock_err_o  = lock_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= TPR_IDLE;
            tpr_q      <= TPR_RESET;
            pend_q     <= TPR_RESET;
            cnt_q      <= '0;
            stall_q    <= 1'b0;
            update_q   <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            lock_err_q <= wr_eff && locked;
            update_q   <= 1'b0;

            case (state_q)
                TPR_IDLE: begin
                    if (wr_ok) begin
                        pend_q  <= new_val;
                        cnt_q   <= CNT_LOAD;
                        state_q <= TPR_DRAIN;
                        stall_q <= 1'b1;
                    end
                end

                TPR_DRAIN: begin
                    if (wr_ok) begin
                        pend_q <= new_val;
                        cnt_q  <= CNT_LOAD;
                    end else if ((cnt_q == '0) && pipe_empty_i) begin
                        // tpr_q moves on this edge so the COMMIT cycle already shows the new policy.
                        tpr_q    <= pend_q;
                        update_q <= 1'b1;
                        state_q  <= TPR_COMMIT;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end

                TPR_COMMIT: begin
                    if (wr_ok) begin
                        pend_q  <= new_val;
                        cnt_q   <= CNT_LOAD;
                        state_q <= TPR_DRAIN;
                    end else begin
                        state_q <= TPR_IDLE;
                        stall_q <= 1'b0;
                    end
                end

                default: begin
                    state_q <= TPR_IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_tpr_ctrl.sv
// Directed and random bench for riscv_tpr_ctrl against a transaction-level model
// that tracks committed value, staged value and the cycle of the last staged write.
module tb_riscv_tpr_ctrl;
    import riscv_tpr_ctrl_pkg::*;

    localparam int          DRAIN = 3;
    localparam logic [31:0] RSTV  = 32'h0000_0000;
    localparam logic [31:0] WMASK = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_empty;
    logic [31:0] tpr;
    logic        stall, upd, lerr;

    always #5 clk = ~clk;

    riscv_tpr_ctrl_if csr ();

    riscv_tpr_ctrl #(
        .TPR_RESET   (RSTV),
        .TPR_WMASK   (WMASK),
        .LOCK_BIT    (31),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .csr           (csr.slave),
        .pipe_empty_i  (pipe_empty),
        .tpr_o         (tpr),
        .tpr_stall_o   (stall),
        .tpr_update_o  (upd),
        .tpr_lock_err_o(lerr)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_tpr, m_pend;
    bit          m_busy, m_cc, m_err;
    int          cyc, m_last;
    int          upd_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_tpr  = RSTV;
        m_pend = RSTV;
        m_busy = 0;
        m_cc   = 0;
        m_err  = 0;
        m_last = 0;
    endtask

    task automatic check_outs();
        chk("tpr_o", tpr, m_tpr);
        chk("rdata", csr.csr_rdata_o, m_busy ? m_pend : m_tpr);
        chk("stall", {31'b0, stall}, {31'b0, (m_busy || m_cc)});
        chk("update", {31'b0, upd}, {31'b0, m_cc});
        chk("lock_err", {31'b0, lerr}, {31'b0, m_err});
    endtask

    // Rules: a staged write commits once DRAIN cycles have passed since the
    // last staged write with the pipe empty and no new write in that cycle.
    task automatic advance(input bit acc, input logic [11:0] addr, input logic [1:0] op,
                           input logic [31:0] wd, input bit pe);
        bit          hit, ro, eff, wr, commit_now;
        logic [31:0] b, nv;
        hit = acc && (addr == CSR_TPR) && (op != 2'd0);
        ro  = ((op == 2'd2) || (op == 2'd3)) && (wd == 32'h0);
        eff = hit && !ro;
        wr  = eff && !m_tpr[31];
        commit_now = m_busy && !wr && ((cyc - m_last) >= DRAIN) && pe;
        m_err = eff && m_tpr[31];
        if (wr) begin
            b = m_busy ? m_pend : m_tpr;
            if (op == 2'd1)      nv = wd;
            else if (op == 2'd2) nv = b | wd;
            else                 nv = b & ~wd;
            m_pend = (nv & WMASK) | (RSTV & ~WMASK);
            m_busy = 1;
            m_last = cyc;
        end
        m_cc = commit_now;
        if (commit_now) begin
            m_tpr  = m_pend;
            m_busy = 0;
        end
        cyc++;
    endtask

    task automatic step(input bit acc, input logic [11:0] addr, input logic [1:0] op,
                        input logic [31:0] wd, input bit pe);
        @(negedge clk);
        csr.csr_access_i = acc;
        csr.csr_addr_i   = addr;
        csr.csr_op_i     = csr_op_e'(op);
        csr.csr_wdata_i  = wd;
        pipe_empty       = pe;
        #1;
        check_outs();
        if (upd) upd_seen++;
        advance(acc, addr, op, wd, pe);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 12'h000, 2'd0, 32'h0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        csr.csr_access_i = 1'b0;
        csr.csr_op_i     = CSR_OP_NONE;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outs();
        chk("rst_tpr", tpr, RSTV);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit          acc, pe;
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] wd;

        rst              = 1'b1;
        pipe_empty       = 1'b1;
        csr.csr_access_i = 1'b0;
        csr.csr_addr_i   = 12'h000;
        csr.csr_op_i     = CSR_OP_NONE;
        csr.csr_wdata_i  = 32'h0;
        model_reset();
        cyc = 0;
        repeat (2) @(negedge clk);
        #1;
        check_outs();
        rst = 1'b0;

        // Reset in the middle of a drain
        step(1'b1, CSR_TPR, 2'd1, 32'h5, 1'b1);
        idle(2);
        chk("mid_drain_stall", {31'b0, stall}, 32'h1);
        do_reset();
        upd_seen = 0;
        idle(6);
        chk("rst_no_update", upd_seen, 0);
        chk("rst_tpr_kept", tpr, RSTV);

        // Plain write: stall for 4 cycles, update in the 4th
        step(1'b1, CSR_TPR, 2'd1, 32'h0000_0A50, 1'b1);
        idle(3);
        chk("a50_stall_t3", {31'b0, stall}, 32'h1);
        chk("a50_tpr_t3", tpr, 32'h0);
        idle(1);
        chk("a50_upd_t4", {31'b0, upd}, 32'h1);
        chk("a50_tpr_t4", tpr, 32'h0000_0A50);
        idle(1);
        chk("a50_stall_t5", {31'b0, stall}, 32'h0);

        // Back-to-back WRITE then SET restarts the drain, single commit
        upd_seen = 0;
        step(1'b1, CSR_TPR, 2'd1, 32'h3, 1'b1);
        step(1'b1, CSR_TPR, 2'd2, 32'h30, 1'b1);
        idle(3);
        chk("merge_tpr_early", tpr, 32'h0000_0A50);
        idle(1);
        chk("merge_tpr", tpr, 32'h33);
        idle(4);
        chk("merge_one_commit", upd_seen, 1);

        // Pipe not empty holds drain
        step(1'b1, CSR_TPR, 2'd1, 32'h77, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 12'h000, 2'd0, 32'h0, 1'b0);
        chk("hold_tpr", tpr, 32'h33);
        chk("hold_stall", {31'b0, stall}, 32'h1);
        step(1'b0, 12'h000, 2'd0, 32'h0, 1'b1);
        idle(1);
        chk("hold_commit", tpr, 32'h77);
        chk("hold_upd", {31'b0, upd}, 32'h1);
        idle(2);

        // Random traffic, lock bit kept clear
        for (int i = 0; i < 600; i++) begin
            acc  = ($urandom_range(0, 3) != 0);
            addr = ($urandom_range(0, 4) != 0) ? CSR_TPR : 12'($urandom_range(0, 4095));
            op   = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       wd = 32'h0;
                1:       wd = 32'h1 << $urandom_range(0, 30);
                default: wd = $urandom & 32'h7FFF_FFFF;
            endcase
            pe = ($urandom_range(0, 9) < 7);
            step(acc, addr, op, wd, pe);
        end
        idle(6);

        // Lock, then attempt a write
        step(1'b1, CSR_TPR, 2'd1, 32'h8000_0001, 1'b1);
        idle(5);
        chk("lock_tpr", tpr, 32'h8000_0001);
        step(1'b1, CSR_TPR, 2'd1, 32'h0, 1'b1);
        idle(1);
        chk("lock_err", {31'b0, lerr}, 32'h1);
        chk("lock_stall", {31'b0, stall}, 32'h0);
        idle(4);
        chk("lock_tpr_kept", tpr, 32'h8000_0001);

        // CLEAR with zero operand while locked is a read
        step(1'b1, CSR_TPR, 2'd3, 32'h0, 1'b1);
        chk("clr0_rdata", csr.csr_rdata_o, 32'h8000_0001);
        idle(1);
        chk("clr0_no_err", {31'b0, lerr}, 32'h0);
        chk("clr0_no_stall", {31'b0, stall}, 32'h0);

        // Reset releases the lock
        do_reset();
        idle(2);
        chk("final_tpr", tpr, RSTV);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
